// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave: the first byte of a transaction sets the pointer,
// later bytes write control registers, and master reads return control or status bytes.
module i2c_reg_bank #(
    parameter int ADDR_W = 4,
    parameter int NRO    = 4
) (
    input  logic                               CLCK,
    input  logic                               reset,
    input  logic [7:0]                         i2c_datain,
    input  logic                               i2c_datain_ready,
    input  logic                               i2c_request,
    input  logic                               i2c_active,
    output logic [7:0]                         i2c_dataout,
    input  logic [NRO*8-1:0]                   status_in,
    output logic [((1<<ADDR_W)-NRO)*8-1:0]     ctrl_out,
    output logic                               wr_strobe,
    output logic [ADDR_W-1:0]                  wr_addr
);

    localparam int NREGS = 1 << ADDR_W;
    localparam int NCTRL = NREGS - NRO;

    // Bit 0 and bit 1 form the synchroniser; bit 2 is the history flop used for edge detection.
    logic [2:0]        readySr_q, reqSr_q, actSr_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              firstByte_q, firstByte_d;
    logic [7:0]        dout_q, dout_d;
    logic              strobe_q, strobe_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [7:0]        ctrl_q [NCTRL];
    logic [7:0]        ctrl_d [NCTRL];

    logic       readyEdge, reqEdge, actEdge;
    logic       isCtrl;
    logic [7:0] readByte;

    assign readyEdge = readySr_q[1] & ~readySr_q[2];
    assign reqEdge   = reqSr_q[1] & ~reqSr_q[2];
    assign actEdge   = actSr_q[1] & ~actSr_q[2];
    assign isCtrl    = ({1'b0, ptr_q} < (ADDR_W+1)'(NCTRL));

    always_comb begin
        readByte = '0;
        for (int k = 0; k < NCTRL; k++) begin
            if (ptr_q == ADDR_W'(k)) readByte = ctrl_q[k];
        end
        for (int k = 0; k < NRO; k++) begin
            if (ptr_q == ADDR_W'(NCTRL + k)) readByte = status_in[k*8 +: 8];
        end
    end

    // A ready edge wins over a simultaneous request edge; an active rise always re-arms the pointer byte.
    always_comb begin
        ptr_d       = ptr_q;
        firstByte_d = firstByte_q;
        dout_d      = dout_q;
        strobe_d    = 1'b0;
        wrAddr_d    = wrAddr_q;
        ctrl_d      = ctrl_q;
        if (readyEdge) begin
            if (firstByte_q) begin
                ptr_d       = i2c_datain[ADDR_W-1:0];
                firstByte_d = 1'b0;
            end else begin
                if (isCtrl) begin
                    for (int k = 0; k < NCTRL; k++) begin
                        if (ptr_q == ADDR_W'(k)) ctrl_d[k] = i2c_datain;
                    end
                    strobe_d = 1'b1;
                    wrAddr_d = ptr_q;
                end
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end else if (reqEdge) begin
            dout_d      = readByte;
            ptr_d       = ptr_q + ADDR_W'(1);
            firstByte_d = 1'b0;
        end
        if (actEdge) firstByte_d = 1'b1;
    end

    always_ff @(posedge CLCK or posedge reset) begin
        if (reset) begin
            readySr_q   <= '0;
            reqSr_q     <= '0;
            actSr_q     <= '0;
            ptr_q       <= '0;
            firstByte_q <= 1'b0;
            dout_q      <= '0;
            strobe_q    <= 1'b0;
            wrAddr_q    <= '0;
            for (int k = 0; k < NCTRL; k++) ctrl_q[k] <= '0;
        end else begin
            readySr_q   <= {readySr_q[1:0], i2c_datain_ready};
            reqSr_q     <= {reqSr_q[1:0], i2c_request};
            actSr_q     <= {actSr_q[1:0], i2c_active};
            ptr_q       <= ptr_d;
            firstByte_q <= firstByte_d;
            dout_q      <= dout_d;
            strobe_q    <= strobe_d;
            wrAddr_q    <= wrAddr_d;
            ctrl_q      <= ctrl_d;
        end
    end

    for (genvar g = 0; g < NCTRL; g++) begin : gCtrlOut
        assign ctrl_out[g*8 +: 8] = ctrl_q[g];
    end

    assign i2c_dataout = dout_q;
    assign wr_strobe   = strobe_q;
    assign wr_addr     = wrAddr_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench for i2c_reg_bank: expected writes and reads are queued as
// stimulus is driven and popped when the DUT strobes or presents read data.
module tb_i2c_reg_bank;

    logic        CLCK = 1'b0;
    logic        reset;
    logic [7:0]  i2c_datain;
    logic        i2c_datain_ready;
    logic        i2c_request;
    logic        i2c_active;
    logic [7:0]  i2c_dataout;
    logic [31:0] status_in;
    logic [95:0] ctrl_out;
    logic        wr_strobe;
    logic [3:0]  wr_addr;

    int checks = 0;
    int failures = 0;

    logic [11:0] writeQ[$];
    logic [7:0]  readQ[$];

    logic [7:0] modelCtrl [12];
    logic [3:0] tbPtr;
    bit         tbFirst;
    logic [7:0] tbLastRead;

    i2c_reg_bank #(.ADDR_W(4), .NRO(4)) dut (
        .CLCK(CLCK),
        .reset(reset),
        .i2c_datain(i2c_datain),
        .i2c_datain_ready(i2c_datain_ready),
        .i2c_request(i2c_request),
        .i2c_active(i2c_active),
        .i2c_dataout(i2c_dataout),
        .status_in(status_in),
        .ctrl_out(ctrl_out),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr)
    );

    always #5 CLCK = ~CLCK;

    // Every strobe must match the oldest queued write, and the register must already hold the byte.
    always @(negedge CLCK) begin : monitor
        logic [11:0] expW;
        if (reset === 1'b0 && wr_strobe === 1'b1) begin
            checks++;
            if (writeQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL strobe_unexpected wr_addr=%0d required=no strobe", wr_addr);
            end else begin
                expW = writeQ.pop_front();
                if (wr_addr !== expW[11:8] || ctrl_out[expW[11:8]*8 +: 8] !== expW[7:0]) begin
                    failures++;
                    $display("[TB] FAIL write_scoreboard addr=%0d data=%h required addr=%0d data=%h",
                             wr_addr, ctrl_out[expW[11:8]*8 +: 8], expW[11:8], expW[7:0]);
                end
            end
        end
    end

    task automatic startTxn();
        @(negedge CLCK); #1;
        i2c_active = 1'b0;
        repeat (5) @(negedge CLCK);
        #1;
        i2c_active = 1'b1;
        repeat (5) @(negedge CLCK);
        tbFirst = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit withReq);
        bit expStrobe;
        int seen;
        expStrobe = 1'b0;
        if (tbFirst) begin
            tbPtr   = b[3:0];
            tbFirst = 1'b0;
        end else begin
            if (tbPtr < 12) begin
                writeQ.push_back({tbPtr, b});
                modelCtrl[tbPtr] = b;
                expStrobe = 1'b1;
            end
            tbPtr = tbPtr + 4'd1;
        end
        @(negedge CLCK); #1;
        i2c_datain = b;
        @(negedge CLCK); #1;
        i2c_datain_ready = 1'b1;
        if (withReq) i2c_request = 1'b1;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLCK);
            if (wr_strobe === 1'b1 && seen == 0) seen = c;
        end
        checks++;
        if (seen != (expStrobe ? 3 : 0)) begin
            failures++;
            $display("[TB] FAIL write_latency byte=%h strobe_cycle=%0d required=%0d", b, seen, expStrobe ? 3 : 0);
        end
        if (withReq) begin
            checks++;
            if (i2c_dataout !== tbLastRead) begin
                failures++;
                $display("[TB] FAIL simultaneous_dataout got=%h required=%h", i2c_dataout, tbLastRead);
            end
        end
        #1;
        i2c_datain_ready = 1'b0;
        i2c_request = 1'b0;
        repeat (4) @(negedge CLCK);
    endtask

    task automatic doRequest();
        logic [7:0] expB;
        if (tbPtr >= 12) expB = status_in[(int'(tbPtr) - 12)*8 +: 8];
        else expB = modelCtrl[tbPtr];
        readQ.push_back(expB);
        tbPtr = tbPtr + 4'd1;
        tbFirst = 1'b0;
        tbLastRead = expB;
        @(negedge CLCK); #1;
        i2c_request = 1'b1;
        repeat (3) @(negedge CLCK);
        expB = readQ.pop_front();
        checks++;
        if (i2c_dataout !== expB) begin
            failures++;
            $display("[TB] FAIL read_data got=%h required=%h", i2c_dataout, expB);
        end
        repeat (2) @(negedge CLCK);
        #1;
        i2c_request = 1'b0;
        repeat (4) @(negedge CLCK);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i2c_datain = '0;
        i2c_datain_ready = 1'b0;
        i2c_request = 1'b0;
        i2c_active = 1'b0;
        status_in = {8'hE7, 8'h99, 8'hC3, 8'h3C};
        for (int k = 0; k < 12; k++) modelCtrl[k] = '0;
        tbPtr = '0;
        tbFirst = 1'b0;
        tbLastRead = '0;
        repeat (3) @(negedge CLCK);
        checks += 4;
        if (ctrl_out !== 96'h0) begin failures++; $display("[TB] FAIL reset_ctrl got=%h required=0", ctrl_out); end
        if (wr_strobe !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobe got=%b required=0", wr_strobe); end
        if (wr_addr !== 4'h0) begin failures++; $display("[TB] FAIL reset_wraddr got=%h required=0", wr_addr); end
        if (i2c_dataout !== 8'h00) begin failures++; $display("[TB] FAIL reset_dataout got=%h required=00", i2c_dataout); end
        #1;
        reset = 1'b0;
        repeat (3) @(negedge CLCK);
    endtask

    task automatic test_basic_write();
        startTxn();
        sendByte(8'h02, 1'b0);
        sendByte(8'hA5, 1'b0);
        sendByte(8'h5A, 1'b0);
        sendByte(8'h66, 1'b0);
        checks += 3;
        if (ctrl_out[23:16] !== 8'hA5) begin failures++; $display("[TB] FAIL basic_reg2 got=%h required=a5", ctrl_out[23:16]); end
        if (ctrl_out[31:24] !== 8'h5A) begin failures++; $display("[TB] FAIL basic_reg3 got=%h required=5a", ctrl_out[31:24]); end
        if (writeQ.size() != 0) begin failures++; $display("[TB] FAIL basic_pending got=%0d required=0", writeQ.size()); end
    endtask

    task automatic test_ro_wrap();
        startTxn();
        sendByte(8'h0F, 1'b0);
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        checks += 2;
        if (ctrl_out[7:0] !== 8'h22) begin failures++; $display("[TB] FAIL wrap_reg0 got=%h required=22", ctrl_out[7:0]); end
        if (writeQ.size() != 0) begin failures++; $display("[TB] FAIL wrap_pending got=%0d required=0", writeQ.size()); end
    endtask

    task automatic test_status_read();
        int changed;
        startTxn();
        sendByte(8'h0C, 1'b0);
        doRequest();
        status_in[7:0] = 8'h00;
        changed = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLCK);
            if (i2c_dataout !== 8'h3C) changed++;
        end
        checks++;
        if (changed != 0) begin failures++; $display("[TB] FAIL read_stable changed_samples=%0d required=0", changed); end
        doRequest();
        checks++;
        if (i2c_dataout !== 8'hC3) begin failures++; $display("[TB] FAIL status_byte1 got=%h required=c3", i2c_dataout); end
    endtask

    task automatic test_restart_pointer();
        startTxn();
        sendByte(8'h01, 1'b0);
        sendByte(8'h77, 1'b0);
        startTxn();
        sendByte(8'h01, 1'b0);
        startTxn();
        doRequest();
        startTxn();
        sendByte(8'h03, 1'b0);
        sendByte(8'h44, 1'b0);
        checks++;
        if (ctrl_out[31:24] !== 8'h44) begin failures++; $display("[TB] FAIL restart_reg3 got=%h required=44", ctrl_out[31:24]); end
    endtask

    task automatic test_simultaneous();
        startTxn();
        sendByte(8'h06, 1'b0);
        sendByte(8'hD2, 1'b0);
        startTxn();
        sendByte(8'h05, 1'b0);
        sendByte(8'hB7, 1'b1);
        doRequest();
        checks++;
        if (ctrl_out[47:40] !== 8'hB7) begin failures++; $display("[TB] FAIL simultaneous_reg5 got=%h required=b7", ctrl_out[47:40]); end
    endtask

    task automatic test_reset_mid();
        logic [95:0] expVec;
        startTxn();
        sendByte(8'h08, 1'b0);
        @(negedge CLCK); #1;
        i2c_datain = 8'h5C;
        @(negedge CLCK); #1;
        i2c_datain_ready = 1'b1;
        @(negedge CLCK); #1;
        reset = 1'b1;
        @(negedge CLCK);
        checks += 3;
        if (ctrl_out !== 96'h0) begin failures++; $display("[TB] FAIL midreset_ctrl got=%h required=0", ctrl_out); end
        if (wr_strobe !== 1'b0) begin failures++; $display("[TB] FAIL midreset_strobe got=%b required=0", wr_strobe); end
        if (i2c_dataout !== 8'h00) begin failures++; $display("[TB] FAIL midreset_dataout got=%h required=00", i2c_dataout); end
        #1;
        i2c_datain_ready = 1'b0;
        repeat (3) @(negedge CLCK);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 12; k++) modelCtrl[k] = '0;
        tbPtr = '0;
        tbFirst = 1'b1;
        tbLastRead = '0;
        repeat (5) @(negedge CLCK);
        sendByte(8'h09, 1'b0);
        sendByte(8'h81, 1'b0);
        expVec = '0;
        for (int k = 0; k < 12; k++) expVec[k*8 +: 8] = modelCtrl[k];
        checks += 2;
        if (ctrl_out !== expVec) begin failures++; $display("[TB] FAIL midreset_after got=%h required=%h", ctrl_out, expVec); end
        if (writeQ.size() != 0) begin failures++; $display("[TB] FAIL midreset_pending got=%0d required=0", writeQ.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_ro_wrap();
        test_status_read();
        test_restart_pointer();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog elapsed=500000 required=finish earlier");
        $fatal(1, "[TB] timeout");
    end

endmodule
